// File: rtl/fifo_stream_reader.sv
// Read-side adapter: drains a single-clock FIFO (showahead or normal mode) into a
// valid/ready stream through a small skid buffer sized to cover the read latency.
module fifo_stream_reader #(
  parameter int unsigned DWIDTH       = 64,
  parameter int unsigned SHOWAHEAD    = 0,
  parameter int unsigned READ_LATENCY = 1,
  localparam int unsigned L           = (SHOWAHEAD != 0) ? 0 : READ_LATENCY,
  localparam int unsigned BUF_DEPTH   = L + 2,
  localparam int unsigned CW          = $clog2(BUF_DEPTH + 1)
) (
  input  logic              clk_i,
  input  logic              srst_i,
  input  logic [DWIDTH-1:0] fifo_q_i,
  input  logic              fifo_empty_i,
  output logic              fifo_rdreq_o,
  input  logic              flush_i,
  output logic [DWIDTH-1:0] data_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [CW-1:0]     words_o
);

  localparam int unsigned PW = $clog2(BUF_DEPTH);
  localparam int unsigned SW = CW + 1;

  logic [DWIDTH-1:0] buf_mem [BUF_DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     buf_cnt;
  logic [CW-1:0]     inflight_cnt;
  logic [CW-1:0]     discard_cnt;
  logic              issue;
  logic              ret;
  logic              push;
  logic              pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Issue only while buffered plus in-flight words leave room; never depends on ready_i.
  assign issue = !srst_i && !flush_i && !fifo_empty_i &&
                 ((SW'(buf_cnt) + SW'(inflight_cnt)) < SW'(BUF_DEPTH));

  assign fifo_rdreq_o = issue;
  assign push         = ret && !flush_i && (discard_cnt == '0);
  assign pop          = (buf_cnt != '0) && ready_i && !flush_i;

  assign valid_o = (buf_cnt != '0);
  assign words_o = buf_cnt;
  assign data_o  = valid_o ? buf_mem[rd_ptr] : '0;

  if (L == 0) begin : g_showahead
    // Showahead: the word is on fifo_q_i in the same cycle as the request.
    assign ret          = issue;
    assign inflight_cnt = '0;
    assign discard_cnt  = '0;
  end else begin : g_normal
    logic [L-1:0] ret_sr;

    assign ret = ret_sr[L-1];

    always_ff @(posedge clk_i) begin
      if (srst_i) begin
        ret_sr       <= '0;
        inflight_cnt <= '0;
        discard_cnt  <= '0;
      end else begin
        ret_sr       <= L'({ret_sr, issue});
        inflight_cnt <= inflight_cnt + CW'(issue) - CW'(ret);
        // A flush drops this cycle's return via push gating; later returns are counted off here.
        if (flush_i) begin
          discard_cnt <= inflight_cnt - CW'(ret);
        end else if (ret && (discard_cnt != '0)) begin
          discard_cnt <= discard_cnt - CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      buf_cnt <= '0;
    end else if (flush_i) begin
      rd_ptr  <= wr_ptr;
      buf_cnt <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      buf_cnt <= buf_cnt + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) buf_mem[wr_ptr] <= fifo_q_i;
  end

  // The issue rule keeps owned words within BUF_DEPTH, so a full buffer only takes a push alongside a pop.
  always_ff @(posedge clk_i) begin
    if (!srst_i) begin
      assert (!(push && !pop && (buf_cnt == CW'(BUF_DEPTH))));
    end
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: three instances (normal RL=1, normal RL=2, showahead)
// each fed by a behavioural FIFO model, checked against directed tables and a scoreboard.
module tb_fifo_stream_reader;

  localparam int unsigned DW = 32;
  localparam int unsigned NI = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          srst;
  logic [NI-1:0] rdy;
  logic [NI-1:0] flush;
  logic [NI-1:0] hide;
  logic [NI-1:0] rdreq_v;
  logic [NI-1:0] valid_v;
  logic [NI-1:0] empty_v;
  logic [DW-1:0] data_a  [NI];
  logic [3:0]    words_a [NI];
  logic [DW-1:0] mem     [NI][2048];
  logic [10:0]   wp      [NI];

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW-1:0] expq [$];
  logic [DW-1:0] sb   [$];
  logic [DW-1:0] v;
  int n_rd, n_wr, bad, maxw, k, stale;

  typedef struct packed {
    logic       rdy;
    logic       rdreq;
    logic       valid;
    logic [3:0] words;
    logic [7:0] data;
  } vec_t;
  vec_t tv [19];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int unsigned SA  = (g == 2) ? 1 : 0;
    localparam int unsigned RL  = (g == 1) ? 2 : 1;
    localparam int unsigned CWG = $clog2(((SA != 0) ? 0 : RL) + 3);
    logic [10:0]    rp;
    logic [DW-1:0]  p1, p2, q, data;
    logic [CWG-1:0] words;
    logic           rdreq, valid;

    // FIFO model: showahead presents mem[rp]; normal mode returns the word RL cycles after rdreq.
    assign empty_v[g] = (wp[g] == rp) || hide[g];
    assign q = (SA != 0) ? mem[g][rp] : ((RL == 2) ? p2 : p1);

    always_ff @(posedge clk) begin
      if (srst) begin
        rp <= wp[g];
        p1 <= '0;
        p2 <= '0;
      end else begin
        if (rdreq) begin
          p1 <= mem[g][rp];
          rp <= rp + 11'd1;
        end
        p2 <= p1;
      end
    end

    fifo_stream_reader #(.DWIDTH(DW), .SHOWAHEAD(SA), .READ_LATENCY(RL)) u_dut (
      .clk_i        (clk),
      .srst_i       (srst),
      .fifo_q_i     (q),
      .fifo_empty_i (empty_v[g]),
      .fifo_rdreq_o (rdreq),
      .flush_i      (flush[g]),
      .data_o       (data),
      .valid_o      (valid),
      .ready_i      (rdy[g]),
      .words_o      (words)
    );

    assign rdreq_v[g] = rdreq;
    assign valid_v[g] = valid;
    assign data_a[g]  = data;
    assign words_a[g] = 4'(words);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  task automatic wr(input int g, input logic [DW-1:0] val);
    mem[g][wp[g]] = val;
    wp[g] = wp[g] + 11'd1;
  endtask

  // Drains instance g with ready held high, matching each popped word against expq in order.
  task automatic collect(input int g, input string nm);
    int kk;
    kk = 0;
    for (int c = 0; c < 100 && kk < expq.size(); c++) begin
      tick();
      #1;
      if (valid_v[g] && rdy[g]) begin
        chk(nm, 64'(data_a[g]), 64'(expq[kk]));
        kk++;
      end
    end
    chk({nm, "_count"}, 64'(kk), 64'(expq.size()));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench timed out after %0d checks", n_tests);
    $fatal(1, "watchdog");
  end

  initial begin
    srst  = 1'b1;
    rdy   = '0;
    flush = '0;
    hide  = '0;
    for (int g = 0; g < NI; g++) wp[g] = '0;
    repeat (3) tick();
    #1;
    for (int g = 0; g < NI; g++) begin
      chk("rst_rdreq", 64'(rdreq_v[g]), 64'd0);
      chk("rst_valid", 64'(valid_v[g]), 64'd0);
      chk("rst_words", 64'(words_a[g]), 64'd0);
    end
    tick();
    srst = 1'b0;

    // Normal RL=1, 0..15 preloaded, ready always high.
    for (int c = 0; c < 21; c++) begin
      tick();
      if (c == 0) for (int i = 0; i < 16; i++) wr(0, DW'(i));
      rdy[0] = 1'b1;
      #1;
      chk("t1_rdreq", 64'(rdreq_v[0]), 64'(c <= 15));
      chk("t1_valid", 64'(valid_v[0]), 64'(c >= 2 && c <= 17));
      chk("t1_rdreq_empty", 64'(rdreq_v[0] & empty_v[0]), 64'd0);
      if (c >= 2 && c <= 17) chk("t1_data", 64'(data_a[0]), 64'(c - 2));
    end

    // RL=2 backpressure: ready low for cycles 0-9, 8 words preloaded.
    tv = '{
      '{1'b0, 1'b1, 1'b0, 4'd0, 8'd0}, '{1'b0, 1'b1, 1'b0, 4'd0, 8'd0},
      '{1'b0, 1'b1, 1'b0, 4'd0, 8'd0}, '{1'b0, 1'b1, 1'b1, 4'd1, 8'd0},
      '{1'b0, 1'b0, 1'b1, 4'd2, 8'd0}, '{1'b0, 1'b0, 1'b1, 4'd3, 8'd0},
      '{1'b0, 1'b0, 1'b1, 4'd4, 8'd0}, '{1'b0, 1'b0, 1'b1, 4'd4, 8'd0},
      '{1'b0, 1'b0, 1'b1, 4'd4, 8'd0}, '{1'b0, 1'b0, 1'b1, 4'd4, 8'd0},
      '{1'b1, 1'b0, 1'b1, 4'd4, 8'd0}, '{1'b1, 1'b1, 1'b1, 4'd3, 8'd1},
      '{1'b1, 1'b1, 1'b1, 4'd2, 8'd2}, '{1'b1, 1'b1, 1'b1, 4'd1, 8'd3},
      '{1'b1, 1'b1, 1'b1, 4'd1, 8'd4}, '{1'b1, 1'b0, 1'b1, 4'd1, 8'd5},
      '{1'b1, 1'b0, 1'b1, 4'd1, 8'd6}, '{1'b1, 1'b0, 1'b1, 4'd1, 8'd7},
      '{1'b1, 1'b0, 1'b0, 4'd0, 8'd0}
    };
    for (int i = 0; i < 19; i++) begin
      tick();
      if (i == 0) for (int j = 0; j < 8; j++) wr(1, DW'(j));
      rdy[1] = tv[i].rdy;
      #1;
      chk("t2_rdreq", 64'(rdreq_v[1]), 64'(tv[i].rdreq));
      chk("t2_valid", 64'(valid_v[1]), 64'(tv[i].valid));
      chk("t2_words", 64'(words_a[1]), 64'(tv[i].words));
      if (tv[i].valid) chk("t2_data", 64'(data_a[1]), 64'(tv[i].data));
    end

    // Showahead, random ready and random FIFO writes against a scoreboard.
    n_rd = 0; n_wr = 0; bad = 0; maxw = 0;
    for (int c = 0; c < 20000 && n_rd < 1000; c++) begin
      tick();
      if (n_wr < 1000 && $urandom_range(1, 0) == 1) begin
        v = $urandom;
        wr(2, v);
        sb.push_back(v);
        n_wr++;
      end
      rdy[2] = 1'($urandom_range(1, 0));
      #1;
      if (int'(words_a[2]) > maxw) maxw = int'(words_a[2]);
      if (rdreq_v[2] && empty_v[2]) bad++;
      if (valid_v[2] && rdy[2]) begin
        if (sb.size() == 0) chk("sa_underflow", 64'd1, 64'd0);
        else chk("sa_data", 64'(data_a[2]), 64'(sb.pop_front()));
        n_rd++;
      end
    end
    chk("sa_count", 64'(n_rd), 64'd1000);
    chk("sa_words_le2", 64'(maxw <= 2), 64'd1);
    chk("sa_rdreq_empty", 64'(bad), 64'd0);
    rdy[2] = 1'b0;

    // Flush on RL=2 with two words buffered and two in flight.
    rdy[1] = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (c == 0) for (int j = 10; j < 20; j++) wr(1, DW'(j));
      if (c == 4) flush[1] = 1'b1;
      if (c == 5) begin
        flush[1] = 1'b0;
        rdy[1]   = 1'b1;
      end
      #1;
      if (c == 4) begin
        chk("fl_words_before", 64'(words_a[1]), 64'd2);
        chk("fl_rdreq_during", 64'(rdreq_v[1]), 64'd0);
      end
      if (c == 5) begin
        chk("fl_valid_after", 64'(valid_v[1]), 64'd0);
        chk("fl_words_after", 64'(words_a[1]), 64'd0);
        chk("fl_rdreq_resume", 64'(rdreq_v[1]), 64'd1);
      end
    end
    expq = {};
    for (int j = 14; j < 20; j++) expq.push_back(DW'(j));
    collect(1, "fl_data");

    // Synchronous reset with two reads in flight.
    for (int c = 0; c < 4; c++) begin
      tick();
      if (c == 0) for (int j = 30; j < 36; j++) wr(1, DW'(j));
      if (c == 2) srst = 1'b1;
      if (c == 3) srst = 1'b0;
      #1;
      if (c == 2) chk("srst_rdreq_during", 64'(rdreq_v[1]), 64'd0);
      if (c == 3) begin
        chk("srst_rdreq", 64'(rdreq_v[1]), 64'd0);
        chk("srst_valid", 64'(valid_v[1]), 64'd0);
        chk("srst_words", 64'(words_a[1]), 64'd0);
        chk("srst_data", 64'(data_a[1]), 64'd0);
      end
    end
    stale = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      #1;
      if (valid_v[1]) stale++;
    end
    chk("srst_no_stale", 64'(stale), 64'd0);
    wr(1, 32'd100);
    wr(1, 32'd101);
    expq = {};
    expq.push_back(32'd100);
    expq.push_back(32'd101);
    collect(1, "srst_data");

    // FIFO toggling empty every other cycle on RL=1.
    for (int j = 200; j < 206; j++) wr(0, DW'(j));
    k = 0; bad = 0;
    for (int c = 0; c < 60 && k < 6; c++) begin
      tick();
      hide[0] = c[0];
      rdy[0]  = 1'b1;
      #1;
      if (rdreq_v[0] && empty_v[0]) bad++;
      if (valid_v[0] && rdy[0]) begin
        chk("tg_data", 64'(data_a[0]), 64'(200 + k));
        k++;
      end
    end
    hide[0] = 1'b0;
    chk("tg_count", 64'(k), 64'd6);
    chk("tg_rdreq_empty", 64'(bad), 64'd0);
    stale = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      #1;
      if (valid_v[0]) stale++;
    end
    chk("tg_no_dup", 64'(stale), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
